// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width,
// FSM state encoding and the nibble-index width helper.
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit so
    // a single-nibble build still has a legal counter.
    function automatic int idx_w(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Request/response bundle of the nibble-serial subtractor.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload steady until that
// edge; ready may rise and fall freely and never depends on valid within
// the same cycle. The request payload is a/b/bin; the response payload is
// diff/bout/ovf/zero.
interface nibble_serial_subtractor_if
    import sub_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    modport master (
        output start_valid, a, b, bin, out_ready,
        input  start_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  start_valid, a, b, bin, out_ready,
        output start_ready, out_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/borrow_lookahead_sub4.sv
// 4-bit borrow-lookahead subtract cell: d = x - y - bin, bout = borrow out.
// Every borrow is written as a flat sum of products of generate/propagate
// terms so no borrow depends on a lower computed borrow.
module borrow_lookahead_sub4
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   bw;

    // Generate: this bit borrows on its own; propagate: equal bits pass a borrow through.
    always_comb begin
        g = ~x & y;
        p = ~(x ^ y);
    end

    // Fully expanded lookahead borrows and the per-bit difference.
    always_comb begin
        bw[0] = bin;
        bw[1] = g[0] | (p[0] & bin);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bin);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bin);
        d     = x ^ y ^ bw[NIBBLE_W-1:0];
        bout  = bw[4];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over 4*NIBBLES bits, one nibble
// per clock through a single time-shared borrow-lookahead cell. Flags are
// computed on the final nibble and held with the result until handoff.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    nibble_serial_subtractor_if.slave  bus,
    output state_t                     state_o
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                borrow_q;
    logic [W-1:0]        diff_q;
    logic                bout_q;
    logic                ovf_q;
    logic                zero_q;

    logic [IDX_W+1:0]    sh_amt;
    logic [W-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic [W-1:0]        nib_mask;
    logic [NIBBLE_W-1:0] d_nib;
    logic                borrow_nib;
    logic [W-1:0]        diff_d;
    logic                ovf_d;
    logic                zero_d;

    // Bit offset of the current nibble and the operand nibbles it selects.
    always_comb begin
        sh_amt   = {idx_q, 2'b00};
        a_sh     = a_q >> sh_amt;
        b_sh     = b_q >> sh_amt;
        nib_mask = W'(4'hF) << sh_amt;
    end

    borrow_lookahead_sub4 u_cell (
        .x    (a_sh[NIBBLE_W-1:0]),
        .y    (b_sh[NIBBLE_W-1:0]),
        .bin  (borrow_q),
        .d    (d_nib),
        .bout (borrow_nib)
    );

    // Result with the current nibble merged in, plus flags as they would be
    // if this is the last nibble.
    always_comb begin
        diff_d = (diff_q & ~nib_mask) | (W'(d_nib) << sh_amt);
        ovf_d  = (a_q[W-1] != b_q[W-1]) & (diff_d[W-1] != a_q[W-1]);
        zero_d = ~|diff_d;
    end

    // Control FSM with operand, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    diff_q   <= diff_d;
                    borrow_q <= borrow_nib;
                    if (idx_q == LAST_IDX) begin
                        bout_q  <= borrow_nib;
                        ovf_q   <= ovf_d;
                        zero_q  <= zero_d;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    always_comb begin
        bus.start_ready = (state_q == IDLE) & ~rst;
        bus.out_valid   = (state_q == DONE);
        bus.diff        = diff_q;
        bus.bout        = bout_q;
        bus.ovf         = ovf_q;
        bus.zero        = zero_q;
        state_o         = state_q;
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed vectors on a 4-nibble
// instance plus back-to-back traffic on 1-, 4- and 16-nibble instances,
// all checked against a plain-arithmetic subtraction model.
module tb_nibble_serial_subtractor;
    import sub_pkg::*;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } model_t;

    int   total = 0;
    int   bad   = 0;
    logic clk;
    logic rst;
    bit   go_b2b = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: w-bit a - b - bin computed with one wide subtraction.
    function automatic model_t model(input logic [63:0] a, input logic [63:0] b,
                                     input logic bin, input int w);
        model_t      m;
        logic [64:0] full;
        logic [63:0] mask;
        mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        full   = {1'b0, a} - {1'b0, b} - 65'(bin);
        m.diff = full[63:0] & mask;
        m.bout = full[w];
        m.ovf  = (a[w-1] != b[w-1]) && (m.diff[w-1] != a[w-1]);
        m.zero = (m.diff == 64'd0);
        return m;
    endfunction

    // ---------------- directed instance (4 nibbles) ----------------
    nibble_serial_subtractor_if #(.NIBBLES(4)) dif ();
    state_t dstate;
    model_t dexp_q[$];

    nibble_serial_subtractor #(.NIBBLES(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (dif.slave),
        .state_o (dstate)
    );

    // Scoreboard: every valid cycle must show the oldest expected result.
    always @(negedge clk) begin
        if (!rst && dif.out_valid) begin
            if (dexp_q.size() == 0) begin
                chk("dir_unexpected_valid", 64'(dif.out_valid), 64'd0);
            end else begin
                chk("dir_diff", 64'(dif.diff), dexp_q[0].diff);
                chk("dir_bout", 64'(dif.bout), 64'(dexp_q[0].bout));
                chk("dir_ovf",  64'(dif.ovf),  64'(dexp_q[0].ovf));
                chk("dir_zero", 64'(dif.zero), 64'(dexp_q[0].zero));
                chk("dir_ready_in_done", 64'(dif.start_ready), 64'd0);
                if (dif.out_ready) void'(dexp_q.pop_front());
            end
        end
    end

    task automatic dsend(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int n;
        n = 0;
        @(negedge clk);
        while (!dif.start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dir_accept_ready", 64'(dif.start_ready), 64'd1);
        dif.a           = a;
        dif.b           = b;
        dif.bin         = bin;
        dif.start_valid = 1'b1;
        dexp_q.push_back(model(64'(a), 64'(b), bin, 16));
        @(posedge clk);
        #1 dif.start_valid = 1'b0;
    endtask

    task automatic dwait_valid(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!dif.out_valid && edges < 50);
        if (!dif.out_valid) chk("dir_valid_timeout", 64'(dif.out_valid), 64'd1);
    endtask

    task automatic dvec(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
        int e;
        int n;
        dsend(a, b, bin);
        dwait_valid(e);
        chk("dir_latency", 64'(e), 64'd4);
        chk("lit_diff", 64'(dif.diff), 64'(ed));
        chk("lit_bout", 64'(dif.bout), 64'(eb));
        chk("lit_ovf",  64'(dif.ovf),  64'(eo));
        chk("lit_zero", 64'(dif.zero), 64'(ez));
        n = 0;
        while (dexp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dir_drained", 64'(dexp_q.size()), 64'd0);
    endtask

    // ---------------- back-to-back instances ----------------
    for (genvar g = 0; g < 3; g++) begin : b2b
        localparam int GN = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        localparam int GW = 4 * GN;

        nibble_serial_subtractor_if #(.NIBBLES(GN)) gif ();
        state_t gstate;
        model_t exp_q[$];
        bit     done = 1'b0;

        nibble_serial_subtractor #(.NIBBLES(GN)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (gif.slave),
            .state_o (gstate)
        );

        // Scoreboard for this instance.
        always @(negedge clk) begin
            if (!rst && gif.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("b2b%0d_unexpected_valid", GN), 64'(gif.out_valid), 64'd0);
                end else begin
                    chk($sformatf("b2b%0d_diff", GN), 64'(gif.diff), exp_q[0].diff);
                    chk($sformatf("b2b%0d_bout", GN), 64'(gif.bout), 64'(exp_q[0].bout));
                    chk($sformatf("b2b%0d_ovf",  GN), 64'(gif.ovf),  64'(exp_q[0].ovf));
                    chk($sformatf("b2b%0d_zero", GN), 64'(gif.zero), 64'(exp_q[0].zero));
                    if (gif.out_ready) void'(exp_q.pop_front());
                end
            end
        end

        // Driver: offer a new request the first cycle the block is ready.
        initial begin
            logic [GW-1:0] ra;
            logic [GW-1:0] rb;
            logic          rbin;
            int            cnt;
            gif.start_valid = 1'b0;
            gif.a           = '0;
            gif.b           = '0;
            gif.bin         = 1'b0;
            gif.out_ready   = 1'b1;
            wait (go_b2b);
            @(negedge clk);
            cnt = 1;
            for (int i = 0; i < 12; i++) begin
                while (!gif.start_ready && cnt < 200) begin
                    @(negedge clk);
                    cnt++;
                end
                if (!gif.start_ready) begin
                    chk($sformatf("b2b%0d_ready_timeout", GN), 64'(gif.start_ready), 64'd1);
                    break;
                end
                if (i > 0) chk($sformatf("b2b%0d_interval", GN), 64'(cnt), 64'(GN + 2));
                ra   = GW'({$urandom(), $urandom()});
                rb   = GW'({$urandom(), $urandom()});
                rbin = 1'($urandom_range(0, 1));
                if (i == 0) begin
                    ra = '0;
                    rb = '1;
                end
                gif.a           = ra;
                gif.b           = rb;
                gif.bin         = rbin;
                gif.start_valid = 1'b1;
                exp_q.push_back(model(64'(ra), 64'(rb), rbin, GW));
                @(posedge clk);
                #1 gif.start_valid = 1'b0;
                @(negedge clk);
                cnt = 1;
            end
            cnt = 0;
            while (exp_q.size() != 0 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk($sformatf("b2b%0d_drained", GN), 64'(exp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int e;
        int n;
        rst             = 1'b1;
        dif.start_valid = 1'b0;
        dif.a           = '0;
        dif.b           = '0;
        dif.bin         = 1'b0;
        dif.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",   64'(dif.out_valid),   64'd0);
        chk("rst_start_ready", 64'(dif.start_ready), 64'd0);
        chk("rst_diff",        64'(dif.diff),        64'd0);
        chk("rst_flags",       64'({dif.bout, dif.ovf, dif.zero}), 64'd0);
        chk("rst_state",       64'(dstate),          64'(IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_start_ready", 64'(dif.start_ready), 64'd1);

        // Directed vectors with hand-computed results.
        dvec(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
        dvec(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        dvec(16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        dvec(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        dvec(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        dvec(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        dvec(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure: result must sit still while the consumer stalls.
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        dsend(16'h9000, 16'h1000, 1'b0);
        dwait_valid(e);
        chk("bp_latency", 64'(e), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            dif.start_valid = ~dif.start_valid;
            dif.a           = 16'($urandom());
            dif.b           = 16'($urandom());
            @(negedge clk);
            chk("bp_start_ready", 64'(dif.start_ready), 64'd0);
            chk("bp_state",       64'(dstate),          64'(DONE));
            chk("bp_diff",        64'(dif.diff),        64'h8000);
        end
        @(posedge clk);
        #1;
        dif.start_valid = 1'b0;
        dif.out_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_after_valid", 64'(dif.out_valid),   64'd0);
        chk("bp_after_state", 64'(dstate),          64'(IDLE));
        chk("bp_after_ready", 64'(dif.start_ready), 64'd1);
        chk("bp_after_queue", 64'(dexp_q.size()),   64'd0);

        // Reset after two nibble edges discards the operation.
        dsend(16'h4321, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dexp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(dif.out_valid),   64'd0);
        chk("mid_rst_diff",  64'(dif.diff),        64'd0);
        chk("mid_rst_flags", 64'({dif.bout, dif.ovf, dif.zero}), 64'd0);
        chk("mid_rst_state", 64'(dstate),          64'(IDLE));
        chk("mid_rst_ready", 64'(dif.start_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(dif.start_ready), 64'd1);
        dvec(16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0, 1'b0);

        // Back-to-back traffic on the 1/4/16-nibble instances.
        go_b2b = 1'b1;
        n = 0;
        while (!(b2b[0].done && b2b[1].done && b2b[2].done) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_all_done", 64'(b2b[0].done && b2b[1].done && b2b[2].done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
